// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RV32 subset control unit (lw, sw, R, I, beq, jal).
// Moore FSM. Datapath controls are registered from the next state; PCWrite,
// IRWrite and ImmSrc add the same-cycle terms that depend on inputs.
// Optional feature macro: MC_MEM_WAIT_EN -- when defined, FETCH, MEMREAD and
// MEMWRITE hold until mem_ready=1. When undefined mem_ready is ignored and
// every state lasts exactly one cycle.
//
// Memory handshake: while the FSM is in a memory state, the access is
// presented for as long as the state is held; mem_ready=1 in a cycle means the
// access completes at the next rising edge, and the FSM advances on that edge.
// mem_ready=0 keeps the FSM in place with the same controls asserted.
module mc_ctrl_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e     state_q, state_d;
  logic       illegal_q;

  // Registered control fields (PCUpdate and Branch are internal terms).
  logic       pcupdate_q, pcupdate_d;
  logic       branch_q, branch_d;
  logic       adrsrc_q, adrsrc_d;
  logic       memwrite_q, memwrite_d;
  logic       irwrite_q, irwrite_d;
  logic       regwrite_q, regwrite_d;
  logic [1:0] resultsrc_q, resultsrc_d;
  logic [1:0] alusrca_q, alusrca_d;
  logic [1:0] alusrcb_q, alusrcb_d;
  logic [1:0] aluop_q, aluop_d;

  // mem_ok is the "memory access completes this cycle" condition.
  logic       mem_ok;
`ifdef MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic       unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  // Next-state selection from the current state and the held opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_ILLEGAL;
      end
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Control word for the state being entered; loaded alongside the state.
  always_comb begin
    pcupdate_d  = 1'b0;
    branch_d    = 1'b0;
    adrsrc_d    = 1'b0;
    memwrite_d  = 1'b0;
    irwrite_d   = 1'b0;
    regwrite_d  = 1'b0;
    resultsrc_d = 2'b00;
    alusrca_d   = 2'b00;
    alusrcb_d   = 2'b00;
    aluop_d     = 2'b00;
    case (state_d)
      S_FETCH: begin
        irwrite_d   = 1'b1;
        alusrcb_d   = 2'b10;
        resultsrc_d = 2'b10;
        pcupdate_d  = 1'b1;
      end
      S_DECODE: begin
        alusrca_d = 2'b01;
        alusrcb_d = 2'b01;
      end
      S_MEMADR: begin
        alusrca_d = 2'b10;
        alusrcb_d = 2'b01;
      end
      S_MEMREAD: adrsrc_d = 1'b1;
      S_MEMWB: begin
        resultsrc_d = 2'b01;
        regwrite_d  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_d   = 1'b1;
        memwrite_d = 1'b1;
      end
      S_EXECUTER: begin
        alusrca_d = 2'b10;
        aluop_d   = 2'b10;
      end
      S_EXECUTEI: begin
        alusrca_d = 2'b10;
        alusrcb_d = 2'b01;
        aluop_d   = 2'b10;
      end
      S_ALUWB: regwrite_d = 1'b1;
      S_BEQ: begin
        alusrca_d = 2'b10;
        aluop_d   = 2'b01;
        branch_d  = 1'b1;
      end
      S_JAL: begin
        alusrca_d  = 2'b01;
        alusrcb_d  = 2'b10;
        pcupdate_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, sticky illegal flag and registered controls. Reset lands in FETCH
  // with the FETCH control word so the first edge after release fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      illegal_q   <= 1'b0;
      pcupdate_q  <= 1'b1;
      branch_q    <= 1'b0;
      adrsrc_q    <= 1'b0;
      memwrite_q  <= 1'b0;
      irwrite_q   <= 1'b1;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 2'b10;
      alusrca_q   <= 2'b00;
      alusrcb_q   <= 2'b10;
      aluop_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_q | (state_d == S_ILLEGAL);
      pcupdate_q  <= pcupdate_d;
      branch_q    <= branch_d;
      adrsrc_q    <= adrsrc_d;
      memwrite_q  <= memwrite_d;
      irwrite_q   <= irwrite_d;
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      alusrca_q   <= alusrca_d;
      alusrcb_q   <= alusrcb_d;
      aluop_q     <= aluop_d;
    end
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are masked by reset_n so nothing is written while held in
  // reset; the FETCH update waits for the memory in the wait-state build.
  logic fetch_ok;
  assign fetch_ok  = (state_q != S_FETCH) | mem_ok;

  assign PCWrite   = reset_n & ((pcupdate_q & fetch_ok) | (branch_q & zero));
  assign IRWrite   = reset_n & irwrite_q & mem_ok;
  assign MemWrite  = reset_n & memwrite_q;
  assign RegWrite  = reset_n & regwrite_q;
  assign AdrSrc    = adrsrc_q;
  assign ResultSrc = resultsrc_q;
  assign ALUSrcA   = alusrca_q;
  assign ALUSrcB   = alusrcb_q;
  assign ALUOp     = aluop_q;
  assign illegal   = illegal_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: bench for mc_ctrl_fsm. Expected state sequences and control
// words come from per-instruction state lists and a per-state output table.
module tb_mc_ctrl_fsm;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .illegal   (illegal),
    .state     (state)
  );

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];

  // observed control word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  logic [12:0] ctrl_obs;
  assign ctrl_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  // ---------------- reference model ----------------
  function automatic logic is_legal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // per-state output table; mr is the memory-complete condition in FETCH
  function automatic logic [12:0] exp_ctrl(input int st, input logic z, input logic mr);
    logic pcu, br, adr, mw, ir, rw;
    logic [1:0] rs, sa, sb, aop;
    pcu = 0; br = 0; adr = 0; mw = 0; ir = 0; rw = 0;
    rs = 0; sa = 0; sb = 0; aop = 0;
    case (st)
      0:  begin ir = mr; pcu = mr; sb = 2'b10; rs = 2'b10; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1;
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      8:  rw = 1;
      9:  begin sa = 2'b10; aop = 2'b01; br = 1; end
      10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
      default: ;
    endcase
    return {pcu | (br & z), adr, mw, ir, rw, rs, sa, sb, aop};
  endfunction

  // states visited by one instruction, starting at FETCH
  task automatic push_seq(input logic [6:0] o);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    case (o)
      OP_LW:  begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      OP_SW:  begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
      OP_R:   begin exp_q.push_back(4'd6); exp_q.push_back(4'd8); end
      OP_I:   begin exp_q.push_back(4'd7); exp_q.push_back(4'd8); end
      OP_BEQ: exp_q.push_back(4'd9);
      OP_JAL: begin exp_q.push_back(4'd10); exp_q.push_back(4'd8); end
      default: exp_q.push_back(4'd11);
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // run one instruction from FETCH; zmode 0/1 fixed zero, 2 random
  task automatic run_instr(input logic [6:0] opc, input int zmode, input string tag);
    push_seq(opc);
    op = opc;
    while (exp_q.size() != 0) begin
      logic [3:0]  st;
      logic [12:0] ec;
      st = exp_q.pop_front();
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
`ifndef MC_MEM_WAIT_EN
      mem_ready = 1'($urandom_range(0, 1));
`endif
      #1;
      ec = exp_ctrl(int'(st), zero, 1'b1);
      total++;
      if (state !== st) begin
        bad++;
        $display("FAIL %s state: got %0d want %0d", tag, state, st);
      end
      total++;
      if (ctrl_obs !== ec) begin
        bad++;
        $display("FAIL %s ctrl st=%0d: got %b want %b", tag, st, ctrl_obs, ec);
      end
      total++;
      if (ImmSrc !== exp_imm(opc)) begin
        bad++;
        $display("FAIL %s immsrc: got %b want %b", tag, ImmSrc, exp_imm(opc));
      end
      total++;
      if (illegal !== (st == 4'd11)) begin
        bad++;
        $display("FAIL %s illegal: got %b want %b", tag, illegal, (st == 4'd11));
      end
      tick();
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    op = 7'($urandom_range(0, 127));
    zero = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got state=%0d illegal=%b want 0/0", state, illegal);
    end
    total++;
    if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_we: got %b want 0000", {PCWrite, MemWrite, IRWrite, RegWrite});
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (state !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got state=%0d ir=%b pc=%b want 0/1/1", state, IRWrite, PCWrite);
    end
    tick();
    total++;
    if (state !== 4'd1) begin
      bad++;
      $display("FAIL first_edge: got state=%0d want 1", state);
    end
    // finish the fetched instruction as an R-type from DECODE
    op = OP_R;
    tick(); tick(); tick();
    total++;
    if (state !== 4'd0) begin
      bad++;
      $display("FAIL reset_r_done: got state=%0d want 0", state);
    end
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 2, "lw");
  endtask

  task automatic test_beq();
    run_instr(OP_BEQ, 1, "beq_z1");
    run_instr(OP_BEQ, 0, "beq_z0");
  endtask

  task automatic test_jal();
    run_instr(OP_JAL, 2, "jal");
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
    ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 5)], 2, "rand");
  endtask

  task automatic test_illegal(input logic [6:0] opc, input int hold);
    run_instr(opc, 2, "illegal_entry");
    for (int i = 0; i < hold; i++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      total++;
      if (state !== 4'd11 || illegal !== 1'b1 || ctrl_obs !== 13'd0) begin
        bad++;
        $display("FAIL illegal_hold: got state=%0d illegal=%b ctrl=%b want 11/1/0",
                 state, illegal, ctrl_obs);
      end
      tick();
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL illegal_reset: got state=%0d illegal=%b want 0/0", state, illegal);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    op = OP_R;
    zero = 1'b0;
    tick(); tick();
    total++;
    if (state !== 4'd6) begin
      bad++;
      $display("FAIL mid_exec: got state=%0d want 6", state);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got state=%0d rw=%b pc=%b want 0/0/0", state, RegWrite, PCWrite);
    end
    tick();
    reset_n = 1'b1;
    run_instr(OP_LW, 2, "after_mid_reset");
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    int mw_cycles;
    op = OP_SW;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
        bad++;
        $display("FAIL fetch_wait: got state=%0d ir=%b pc=%b want 0/0/0", state, IRWrite, PCWrite);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      bad++;
      $display("FAIL fetch_go: got ir=%b pc=%b want 1/1", IRWrite, PCWrite);
    end
    tick(); tick(); tick();
    mw_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      total++;
      if (state !== 4'd5) begin
        bad++;
        $display("FAIL memwrite_hold: got state=%0d want 5", state);
      end
      if (MemWrite === 1'b1) mw_cycles++;
      tick();
    end
    total++;
    if (mw_cycles != 4) begin
      bad++;
      $display("FAIL memwrite_cycles: got %0d want 4", mw_cycles);
    end
    total++;
    if (state !== 4'd0) begin
      bad++;
      $display("FAIL memwrite_done: got state=%0d want 0", state);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_jal();
    test_back_to_back();
    test_illegal(7'b1111111, 10);
    begin
      logic [6:0] rop;
      rop = 7'($urandom_range(0, 127));
      while (is_legal(rop)) rop = 7'($urandom_range(0, 127));
      test_illegal(rop, 3);
    end
    test_reset_mid();
`ifdef MC_MEM_WAIT_EN
    test_mem_wait();
`endif
    run_instr(OP_SW, 2, "final_sw");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
